// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshakes and a full flag set
// Optional shift-add multiplier (op 10) is built when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic [TAG_W-1:0] out_tag,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf,
   output logic             err
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_SRL  = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;

`ifdef ALU_PIPE_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'd10;
   typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_e;
`else
   typedef enum logic {IDLE = 1'b0} state_e;
`endif

   state_e state_q, state_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

   logic             accept;
   logic             ld_alu;
   logic [WIDTH-1:0] alu_c;
   logic             alu_carry, alu_ovf, alu_err;
   logic [WIDTH:0]   sum_w, diff_w;
   logic [SHW-1:0]   shamt;

   // rst_n gates only the outward ready; the flops are already held by the async reset
   assign in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && (state_q == IDLE) && (!out_valid_q || out_ready);

   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = {1'b0, a} - {1'b0, b};
   assign shamt  = b[SHW-1:0];

   always_comb begin
      alu_c     = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      alu_err   = 1'b0;
      case (op)
         OP_AND:  alu_c = a & b;
         OP_OR:   alu_c = a | b;
         OP_XOR:  alu_c = a ^ b;
         OP_ADD: begin
            alu_c     = sum_w[WIDTH-1:0];
            alu_carry = sum_w[WIDTH];
            alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // the extra top bit of the difference is the unsigned borrow (a < b)
            alu_c     = diff_w[WIDTH-1:0];
            alu_carry = diff_w[WIDTH];
            alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLL:  alu_c = a << shamt;
         OP_SRL:  alu_c = a >> shamt;
         OP_SRA:  alu_c = WIDTH'($signed(a) >>> shamt);
         OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_c = {{(WIDTH-1){1'b0}}, (a < b)};
         default: alu_err = 1'b1;
      endcase
   end

`ifdef ALU_PIPE_MUL_EN
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] acc_next;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [TAG_W-1:0] mtag_q, mtag_d;
   logic             mul_done;

   assign ld_alu   = accept && (op != OP_MUL);
   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_done = (state_q == MUL_BUSY) && (cnt_q == SHW'(WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mtag_d   = mtag_q;
      case (state_q)
         IDLE: begin
            if (accept && (op == OP_MUL)) begin
               state_d  = MUL_BUSY;
               mcand_d  = a;
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               mtag_d   = in_tag;
            end
         end
         MUL_BUSY: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (mul_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         mtag_q   <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         mtag_q   <= mtag_d;
      end
   end
`else
   assign ld_alu = accept;

   always_comb begin
      state_d = state_q;
   end
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      c_d         = c_q;
      tag_d       = tag_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (ld_alu) begin
         out_valid_d = 1'b1;
         c_d         = alu_c;
         tag_d       = in_tag;
         zero_d      = (alu_c == '0);
         neg_d       = alu_c[WIDTH-1];
         carry_d     = alu_carry;
         ovf_d       = alu_ovf;
         err_d       = alu_err;
      end
`ifdef ALU_PIPE_MUL_EN
      // the in_ready rule guarantees the output register is empty when the product lands
      else if (mul_done) begin
         out_valid_d = 1'b1;
         c_d         = acc_next;
         tag_d       = mtag_q;
         zero_d      = (acc_next == '0);
         neg_d       = acc_next[WIDTH-1];
         carry_d     = 1'b0;
         ovf_d       = 1'b0;
         err_d       = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         c_q         <= '0;
         tag_q       <= '0;
         zero_q      <= 1'b1;
         neg_q       <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         c_q         <= c_d;
         tag_q       <= tag_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign c         = c_q;
   assign out_tag   = tag_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe (WIDTH=32, TAG_W=4)
// Directed vector table, handshake corner sequences and a randomized scoreboard run.
module tb_alu_pipe;
   logic        clk, rst_n, in_valid, out_ready;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic [3:0]  in_tag;
   logic        in_ready, out_valid;
   logic [31:0] c;
   logic [3:0]  out_tag;
   logic        zero, neg, carry, ovf, err;

   int checks = 0;
   int failures = 0;

   alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .c(c), .out_tag(out_tag),
      .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] c;
      logic [4:0]  f;   // {zero, neg, carry, ovf, err}
   } vec_t;

   typedef struct {
      logic [31:0] c;
      logic [3:0]  tag;
      logic [4:0]  f;
   } res_t;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic res_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [3:0] t);
      res_t   r;
      longint sx, sy, s, u;
      int     sh;
      logic   cy, ov, er;
      r.c = 32'h0; r.tag = t; cy = 1'b0; ov = 1'b0; er = 1'b0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      sh = int'(y % 32);
      case (o)
         4'd0: r.c = x & y;
         4'd1: r.c = x | y;
         4'd3: r.c = x ^ y;
         4'd2: begin
            u = longint'(x) + longint'(y);
            r.c = 32'(u);
            cy = (u > 64'sh0FFFFFFFF);
            s = sx + sy;
            ov = (s > SMAX) || (s < SMIN);
         end
         4'd6: begin
            r.c = x - y;
            cy = (x < y);
            s = sx - sy;
            ov = (s > SMAX) || (s < SMIN);
         end
         4'd4: r.c = x << sh;
         4'd5: r.c = x >> sh;
         4'd7: r.c = 32'(sx >>> sh);
         4'd8: r.c = (sx < sy) ? 32'd1 : 32'd0;
         4'd9: r.c = (x < y) ? 32'd1 : 32'd0;
`ifdef ALU_PIPE_MUL_EN
         4'd10: r.c = 32'(longint'(x) * longint'(y));
`endif
         default: er = 1'b1;
      endcase
      r.f = {(r.c == 32'h0), r.c[31], cy, ov, er};
      return r;
   endfunction

   vec_t vecs[$];
   res_t exp_r;
   bit   pend, exp_rdy;
   int   e;

   initial begin
      vecs.push_back('{4'd2,  32'hFFFFFFFF, 32'h00000001, 4'h1, 32'h00000000, 5'b10100});
      vecs.push_back('{4'd6,  32'h80000000, 32'h00000001, 4'h2, 32'h7FFFFFFF, 5'b00010});
      vecs.push_back('{4'd8,  32'hFFFFFFFF, 32'h00000001, 4'h3, 32'h00000001, 5'b00000});
      vecs.push_back('{4'd9,  32'hFFFFFFFF, 32'h00000001, 4'h4, 32'h00000000, 5'b10000});
      vecs.push_back('{4'd7,  32'h80000000, 32'h00000024, 4'h5, 32'hF8000000, 5'b01000});
      vecs.push_back('{4'd4,  32'h12345678, 32'h00000020, 4'h6, 32'h12345678, 5'b00000});
      vecs.push_back('{4'd15, 32'h00000005, 32'h00000003, 4'hA, 32'h00000000, 5'b10001});
      vecs.push_back('{4'd2,  32'h7FFFFFFF, 32'h00000001, 4'h7, 32'h80000000, 5'b01010});
      vecs.push_back('{4'd6,  32'h00000000, 32'h00000001, 4'h8, 32'hFFFFFFFF, 5'b01100});
      vecs.push_back('{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 4'h9, 32'hF000F000, 5'b01000});
      vecs.push_back('{4'd1,  32'h0F0F0000, 32'h000000F0, 4'hB, 32'h0F0F00F0, 5'b00000});
      vecs.push_back('{4'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, 4'hC, 32'h00000000, 5'b10000});
      vecs.push_back('{4'd5,  32'h80000000, 32'hFFFFFFFF, 4'hD, 32'h00000001, 5'b00000});
      vecs.push_back('{4'd4,  32'h00000001, 32'h0000001F, 4'hE, 32'h80000000, 5'b01000});
      vecs.push_back('{4'd8,  32'h00000001, 32'hFFFFFFFF, 4'hF, 32'h00000000, 5'b10000});
      vecs.push_back('{4'd6,  32'h00000005, 32'h00000005, 4'h0, 32'h00000000, 5'b10000});
      vecs.push_back('{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h2, 32'h00000000, 5'b10001});
`ifndef ALU_PIPE_MUL_EN
      vecs.push_back('{4'd10, 32'h00000006, 32'h00000007, 4'h3, 32'h00000000, 5'b10001});
`endif

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = '0; b = '0; in_tag = '0;
      #1;
      chk("reset_in_ready", in_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_c", c, 0);
      chk("reset_tag", out_tag, 0);
      chk("reset_flags", {zero, neg, carry, ovf, err}, 5'b10000);
      chk("reset_ready_after", in_ready, 1);

      // directed table, one op at a time with the consumer always ready
      out_ready = 1'b1;
      @(negedge clk);
      foreach (vecs[i]) begin
         op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; in_tag = vecs[i].tag; in_valid = 1'b1;
         #1;
         chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_c", i), c, vecs[i].c);
         chk($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
         chk($sformatf("vec%0d_flags", i), {zero, neg, carry, ovf, err}, vecs[i].f);
      end
      @(negedge clk);
      chk("drain_out_valid", out_valid, 0);

      // backpressure: only the first op is taken while the result is held
      out_ready = 1'b0; in_valid = 1'b1; op = 4'd2; a = 32'd10; b = 32'd20; in_tag = 4'd1;
      #1;
      chk("bp_first_ready", in_ready, 1);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready_low", in_ready, 0);
      chk("bp_c0", c, 32'd30);
      a = 32'd100; b = 32'd1; in_tag = 4'd2;
      @(negedge clk);
      chk("bp_c_stable1", c, 32'd30);
      chk("bp_tag_stable1", out_tag, 4'd1);
      chk("bp_ready_low2", in_ready, 0);
      op = 4'd3; a = 32'd7; b = 32'd7; in_tag = 4'd3;
      @(negedge clk);
      chk("bp_c_stable2", c, 32'd30);
      chk("bp_tag_stable2", out_tag, 4'd1);
      op = 4'd2; a = 32'd100; b = 32'd1; in_tag = 4'd2; out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      @(negedge clk);
      chk("bp_tp_valid1", out_valid, 1);
      chk("bp_tp_tag2", out_tag, 4'd2);
      chk("bp_tp_c2", c, 32'd101);
      op = 4'd3; a = 32'd7; b = 32'd7; in_tag = 4'd3;
      @(negedge clk);
      chk("bp_tp_valid2", out_valid, 1);
      chk("bp_tp_tag3", out_tag, 4'd3);
      chk("bp_tp_c3", c, 32'd0);
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);

      // async reset while a result is held
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_c", c, 0);
      chk("arst_tag", out_tag, 0);
      chk("arst_flags", {zero, neg, carry, ovf, err}, 5'b10000);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;

`ifdef ALU_PIPE_MUL_EN
      in_valid = 1'b1; op = 4'd10; a = 32'h00010000; b = 32'h00010001; in_tag = 4'd5;
      @(negedge clk);
      in_valid = 1'b0;
      e = 0;
      chk("mul_busy_ready", in_ready, 0);
      while (!out_valid && e < 100) begin
         @(negedge clk);
         e++;
      end
      chk("mul_latency", e, 32);
      chk("mul_c", c, 32'h00010000);
      chk("mul_tag", out_tag, 4'd5);
      chk("mul_flags", {zero, neg, carry, ovf, err}, 5'b00000);
      @(negedge clk);
      in_valid = 1'b1; op = 4'd10; a = 32'h12345; b = 32'h777; in_tag = 4'd6;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mul_rst_valid", out_valid, 0);
      chk("mul_rst_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mul_rst_idle", in_ready, 1);
      e = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) e++;
      end
      chk("mul_rst_discard", e, 0);
`endif

      // randomized run against the reference model
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      pend = 1'b0;
      for (int i = 0; i < 400; i++) begin
         chk("rnd_out_valid", out_valid, pend);
         if (pend) begin
            chk("rnd_c", c, exp_r.c);
            chk("rnd_tag", out_tag, exp_r.tag);
            chk("rnd_flags", {zero, neg, carry, ovf, err}, exp_r.f);
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         op = 4'($urandom_range(0, 15));
`ifdef ALU_PIPE_MUL_EN
         if (op == 4'd10) op = 4'd2;
`endif
         a = $urandom;
         b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
         in_tag = 4'($urandom);
         #1;
         exp_rdy = !pend || out_ready;
         chk("rnd_in_ready", in_ready, exp_rdy);
         if (pend && out_ready) pend = 1'b0;
         if (in_valid && exp_rdy) begin
            pend  = 1'b1;
            exp_r = model(op, a, b, in_tag);
         end
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
